// File: rtl/dff_checker.sv
// dff_checker: watches a D flip-flop with synchronous active-high reset and flags any cycle
// where its output differs from a reference copy built from the same d_in/dut_rst stimulus.
//
// Optional feature: define DFF_CHECKER_QB_CHECK_EN to also flag qb_out != ~q_out in CHECK.
// Without it, qb_out is accepted and ignored.
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   reset_i        synchronous active-high checker reset
//   enable_i       1 = run checking, 0 = return to IDLE (ignored in FAIL)
//   clear_i        synchronous clear of counts/sticky flag; also FAIL -> IDLE
//   dut_rst_i      copy of the reset driven to the observed flip-flop
//   d_in_i         copy of the data driven to the observed flip-flop
//   q_out_i        observed flip-flop output
//   qb_out_i       observed flip-flop complement output
//   err_o          one-cycle pulse per detected mismatch
//   err_sticky_o   set on first mismatch, held until clear/reset
//   err_count_o    saturating mismatch count
//   chk_count_o    saturating comparison count
//   state_o        IDLE=00, ARMED=01, CHECK=10, FAIL=11
module dff_checker #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_ERR = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             dut_rst_i,
  input  logic             d_in_i,
  input  logic             q_out_i,
  input  logic             qb_out_i,
  output logic             err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] chk_count_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StCheck = 2'b10,
    StFail  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MaxErr = CNT_W'(MAX_ERR);

  state_e           state_q, state_d;
  logic             exp_q, exp_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

  logic             compare;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt_inc;
  logic [CNT_W-1:0] chk_cnt_inc;

`ifdef DFF_CHECKER_QB_CHECK_EN
  assign mismatch = (q_out_i != exp_q) || (qb_out_i != ~q_out_i);
`else
  logic unused_qb;
  assign unused_qb = qb_out_i;
  assign mismatch  = (q_out_i != exp_q);
`endif

  assign err_cnt_inc = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + CNT_W'(1);
  assign chk_cnt_inc = (chk_cnt_q == CntMax) ? chk_cnt_q : chk_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    // Reference flip-flop tracks the stimulus in every state.
    exp_d     = dut_rst_i ? 1'b0 : d_in_i;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    compare   = 1'b0;

    unique case (state_q)
      StIdle:  if (enable_i) state_d = StArmed;
      StArmed: state_d = enable_i ? StCheck : StIdle;
      StCheck: begin
        if (!enable_i) state_d = StIdle;
        else           compare = 1'b1;
      end
      StFail:  sticky_d = 1'b1;
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      // Clear wins over a coincident mismatch: no pulse, no count, no FAIL entry.
      err_cnt_d = '0;
      chk_cnt_d = '0;
      sticky_d  = 1'b0;
      if (state_q == StFail) state_d = StIdle;
    end else if (compare) begin
      chk_cnt_d = chk_cnt_inc;
      if (mismatch) begin
        err_d     = 1'b1;
        sticky_d  = 1'b1;
        err_cnt_d = err_cnt_inc;
        if (err_cnt_inc == MaxErr) state_d = StFail;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      exp_q     <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign err_count_o  = err_cnt_q;
  assign chk_count_o  = chk_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dff_checker.sv
// Scoreboard bench for dff_checker: stimulus pushes hand-computed expected outputs per edge,
// a monitor pops one entry after every rising edge and compares.
module tb_dff_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, clear = 1'b0, dut_rst = 1'b0, d_in = 1'b0;
  logic       inv = 1'b0, qb_bad = 1'b0;
  logic       ff_q = 1'b0;
  logic       q_out, qb_out;
  logic       err, err_sticky;
  logic [7:0] err_count, chk_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       care;
    logic       err;
    logic       stk;
    logic [7:0] ec;
    logic [7:0] cc;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Correct flip-flop under observation; inv/qb_bad inject faults on its outputs.
  always @(posedge clk) ff_q <= dut_rst ? 1'b0 : d_in;
  assign q_out  = ff_q ^ inv;
  assign qb_out = qb_bad ? q_out : ~q_out;

  dff_checker #(.CNT_W(8), .MAX_ERR(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .clear_i      (clear),
    .dut_rst_i    (dut_rst),
    .d_in_i       (d_in),
    .q_out_i      (q_out),
    .qb_out_i     (qb_out),
    .err_o        (err),
    .err_sticky_o (err_sticky),
    .err_count_o  (err_count),
    .chk_count_o  (chk_count),
    .state_o      (state)
  );

  task automatic cmp(input string tag, input string fld, input logic [7:0] act,
                     input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got %0h want %0h", tag, fld, act, want);
    end
  endtask

  // One edge: drive inputs at negedge, queue the outputs expected after the next posedge.
  task automatic vec(input string tag, input logic rst, input logic en, input logic clr,
                     input logic drst, input logic d, input logic iv, input logic qbb,
                     input logic care, input logic e_err, input logic e_stk,
                     input logic [7:0] e_ec, input logic [7:0] e_cc, input logic [1:0] e_st);
    exp_t e;
    @(negedge clk);
    reset = rst; enable = en; clear = clr; dut_rst = drst; d_in = d; inv = iv; qb_bad = qbb;
    e.tag = tag; e.care = care; e.err = e_err; e.stk = e_stk;
    e.ec = e_ec; e.cc = e_cc; e.st = e_st;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.care) begin
          cmp(e.tag, "err", {7'd0, err}, {7'd0, e.err});
          cmp(e.tag, "sticky", {7'd0, err_sticky}, {7'd0, e.stk});
          cmp(e.tag, "err_count", err_count, e.ec);
          cmp(e.tag, "chk_count", chk_count, e.cc);
          cmp(e.tag, "state", {6'd0, state}, {6'd0, e.st});
        end
      end
    end
  end

  logic qb_exp;

  initial begin : stim
`ifdef DFF_CHECKER_QB_CHECK_EN
    qb_exp = 1'b1;
`else
    qb_exp = 1'b0;
`endif
    //    tag         rst en clr drst d inv qbb care err stk ec  cc  st
    vec("reset0",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    vec("reset1",     1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    // Correct flip-flop, 5 compares
    vec("arm",        0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd1);
    vec("armed",      0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd2);
    vec("cmp1",       0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'd2);
    vec("cmp2",       0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 2'd2);
    vec("cmp3",       0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 2'd2);
    vec("cmp4",       0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4, 2'd2);
    vec("cmp5",       0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5, 2'd2);
    // Single forced mismatch
    vec("mis1",       0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 6, 2'd2);
    vec("mis1_after", 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 7, 2'd2);
    // dut_rst pulse with d_in=1: expected 0 is checked on the next edge
    vec("drst",       0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 8, 2'd2);
    vec("drst_next",  0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 9, 2'd2);
    // clear together with a mismatch, then reset mid-CHECK
    vec("clr_mis",    0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd2);
    vec("post_clr",   0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 2'd2);
    vec("rst_mid",    1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0);
    vec("idle",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    // Four mismatches reach MAX_ERR -> FAIL
    vec("arm2",       0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd1);
    vec("armed2",     0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd2);
    vec("f1",         0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 2'd2);
    vec("f2",         0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 2, 2, 2'd2);
    vec("f3",         0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 3, 3, 2'd2);
    vec("f4",         0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 4, 4, 2'd3);
    vec("f5",         0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 4, 4, 2'd3);
    vec("fail_en0",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 4, 2'd3);
    vec("fail_clr",   0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    vec("idle2",      0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    // chk_count saturation
    vec("arm3",       0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd1);
    vec("armed3",     0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd2);
    for (int i = 1; i <= 260; i++) begin
      vec("sat", 0, 1, 0, 0, 1'(i), 0, 0, (i == 255 || i == 260), 0, 0, 0,
          8'(i > 255 ? 255 : i), 2'd2);
    end
    // Complement output equal to q_out
    vec("qb_bad",     0, 1, 0, 0, 0, 0, 1, 1, qb_exp, qb_exp, {7'd0, qb_exp}, 255, 2'd2);
    vec("check_en0",  0, 0, 0, 0, 1, 0, 0, 1, 0, qb_exp, {7'd0, qb_exp}, 255, 2'd0);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
